// File: rtl/billiard_pkg.sv
// Shared types and default constants for the billiard display blocks.
package billiard_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AIM      = 3'd1,
    ROLL     = 3'd2,
    SCORED   = 3'd3,
    FOUL     = 3'd4,
    GAMEOVER = 3'd5
  } seq_state_t;

  // Defaults shared with the hole-number and score drawers.
  localparam int unsigned DEFAULT_NUM_HOLES     = 6;
  localparam int unsigned DEFAULT_MAX_SCORE     = 9;
  localparam int unsigned DEFAULT_RESULT_FRAMES = 60;

endpackage

// File: rtl/layer_sequencer_if.sv
// Game-side signals of the layer sequencer: events in, layer enables and status out.
interface layer_sequencer_if #(
  parameter int unsigned HOLE_W = 3
);
  logic              startOfFrame;
  logic              shotReq;
  logic              ballsMoving;
  logic              redPocketed;
  logic [HOLE_W-1:0] pocketHole;
  logic              whitePocketed;

  logic              whiteBallEn;
  logic              redBallEn;
  logic              holeNumberEn;
  logic              holesEn;
  logic              bordersEn;
  logic              boardEn;
  logic [HOLE_W-1:0] targetHole;
  logic [3:0]        score;
  logic [2:0]        stateOut;

  // Game/display side: drives events, consumes enables and status.
  modport master (
    output startOfFrame, shotReq, ballsMoving, redPocketed, pocketHole, whitePocketed,
    input  whiteBallEn, redBallEn, holeNumberEn, holesEn, bordersEn, boardEn,
    input  targetHole, score, stateOut
  );

  // Sequencer side.
  modport slave (
    input  startOfFrame, shotReq, ballsMoving, redPocketed, pocketHole, whitePocketed,
    output whiteBallEn, redBallEn, holeNumberEn, holesEn, bordersEn, boardEn,
    output targetHole, score, stateOut
  );
endinterface

// File: rtl/frame_timer.sv
// Frame-based timer: saturating frame counter plus a blink bit, both restarted by i_clear.
module frame_timer #(
  parameter int unsigned BLINK_FRAMES  = 16,
  parameter int unsigned RESULT_FRAMES = 60,
  parameter int unsigned CNT_W         = $clog2(RESULT_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_start_of_frame,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic             o_blink
);

  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]   r_frame_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;

  // Count frames (saturating) and toggle blink every BLINK_FRAMES frames; clear wins over a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (i_clear) begin
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (i_start_of_frame) begin
      if (r_frame_cnt != CNT_W'(RESULT_FRAMES)) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_blink     = r_blink;

endmodule

// File: rtl/layer_sequencer.sv
// Game-flow controller: sequences aim/roll/score/foul/game-over and gates the drawing layers.
module layer_sequencer
  import billiard_pkg::*;
#(
  parameter int unsigned NUM_HOLES       = DEFAULT_NUM_HOLES,
  parameter int unsigned BLINK_FRAMES    = 16,
  parameter int unsigned RESULT_FRAMES   = DEFAULT_RESULT_FRAMES,
  parameter int unsigned MAX_SCORE       = DEFAULT_MAX_SCORE,
  parameter int unsigned MIN_ROLL_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  layer_sequencer_if.slave   bus
);

  localparam int unsigned HOLE_W = $clog2(NUM_HOLES);
  localparam int unsigned CNT_W  = $clog2(RESULT_FRAMES + 1);

  // Enable vector bit order: {white, red, holeNumber, holes, borders, board}.
  localparam int unsigned EN_BOARD   = 0;
  localparam int unsigned EN_BORDERS = 1;
  localparam int unsigned EN_HOLES   = 2;
  localparam int unsigned EN_HOLENUM = 3;
  localparam int unsigned EN_RED     = 4;
  localparam int unsigned EN_WHITE   = 5;

  seq_state_t        r_state, w_state_next;
  logic [3:0]        r_score, w_score_next;
  logic [HOLE_W-1:0] r_target, w_target_next;
  logic [5:0]        r_en, w_en_next;
  logic [CNT_W-1:0]  w_frame_cnt;
  logic              w_blink;
  logic              w_state_entry;
  logic [3:0]        w_score_inc;

  // Timer restarts on every state entry so each phase starts at frame 0 with blink on.
  assign w_state_entry = (w_state_next != r_state);

  frame_timer #(
    .BLINK_FRAMES  (BLINK_FRAMES),
    .RESULT_FRAMES (RESULT_FRAMES),
    .CNT_W         (CNT_W)
  ) u_frame_timer (
    .clk              (clk),
    .reset            (reset),
    .i_clear          (w_state_entry),
    .i_start_of_frame (bus.startOfFrame),
    .o_frame_cnt      (w_frame_cnt),
    .o_blink          (w_blink)
  );

  assign w_score_inc = r_score + 4'd1;

  // Next-state, score and target decisions.
  always_comb begin
    w_state_next  = r_state;
    w_score_next  = r_score;
    w_target_next = r_target;
    case (r_state)
      IDLE: begin
        if (bus.shotReq) w_state_next = AIM;
      end
      AIM: begin
        if (bus.shotReq) w_state_next = ROLL;
      end
      ROLL: begin
        // Pocket events take priority over the end-of-roll check.
        if (bus.whitePocketed) begin
          w_state_next = FOUL;
        end else if (bus.redPocketed) begin
          w_state_next = (bus.pocketHole == r_target) ? SCORED : FOUL;
        end else if (bus.startOfFrame && !bus.ballsMoving &&
                     (w_frame_cnt >= CNT_W'(MIN_ROLL_FRAMES))) begin
          w_state_next = AIM;
        end
      end
      SCORED: begin
        if (w_frame_cnt == CNT_W'(RESULT_FRAMES)) begin
          w_score_next  = w_score_inc;
          w_target_next = (r_target == HOLE_W'(NUM_HOLES - 1)) ? '0 : r_target + 1'b1;
          w_state_next  = (w_score_inc == 4'(MAX_SCORE)) ? GAMEOVER : AIM;
        end
      end
      FOUL: begin
        if (w_frame_cnt == CNT_W'(RESULT_FRAMES)) begin
          w_score_next = (r_score != 4'd0) ? r_score - 4'd1 : 4'd0;
          w_state_next = AIM;
        end
      end
      GAMEOVER: begin
        if (bus.shotReq) begin
          w_state_next  = IDLE;
          w_score_next  = 4'd0;
          w_target_next = '0;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_score_next  = 4'd0;
        w_target_next = '0;
      end
    endcase
  end

  // Layer enables derived from the current state; registered below, so they trail by one cycle.
  always_comb begin
    w_en_next = '0;
    case (r_state)
      IDLE: begin
        w_en_next[EN_BOARD]   = 1'b1;
        w_en_next[EN_BORDERS] = 1'b1;
        w_en_next[EN_HOLES]   = 1'b1;
        w_en_next[EN_HOLENUM] = w_blink;
      end
      AIM, ROLL: begin
        w_en_next = '1;
      end
      SCORED: begin
        w_en_next[EN_BOARD]   = 1'b1;
        w_en_next[EN_BORDERS] = 1'b1;
        w_en_next[EN_HOLES]   = 1'b1;
        w_en_next[EN_WHITE]   = 1'b1;
        w_en_next[EN_HOLENUM] = w_blink;
      end
      FOUL: begin
        w_en_next[EN_BOARD]   = 1'b1;
        w_en_next[EN_BORDERS] = 1'b1;
        w_en_next[EN_HOLES]   = 1'b1;
        w_en_next[EN_RED]     = 1'b1;
        w_en_next[EN_HOLENUM] = 1'b1;
        w_en_next[EN_WHITE]   = w_blink;
      end
      GAMEOVER: begin
        w_en_next[EN_BOARD]   = 1'b1;
        w_en_next[EN_BORDERS] = 1'b1;
      end
      default: w_en_next = '0;
    endcase
  end

  // State, score, target and enable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_score  <= 4'd0;
      r_target <= '0;
      r_en     <= '0;
    end else begin
      r_state  <= w_state_next;
      r_score  <= w_score_next;
      r_target <= w_target_next;
      r_en     <= w_en_next;
    end
  end

  assign bus.boardEn      = r_en[EN_BOARD];
  assign bus.bordersEn    = r_en[EN_BORDERS];
  assign bus.holesEn      = r_en[EN_HOLES];
  assign bus.holeNumberEn = r_en[EN_HOLENUM];
  assign bus.redBallEn    = r_en[EN_RED];
  assign bus.whiteBallEn  = r_en[EN_WHITE];
  assign bus.targetHole   = r_target;
  assign bus.score        = r_score;
  assign bus.stateOut     = r_state;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Game-flow controller for the billiard display.
- Owns the per-layer enables that gate every drawing request feeding the priority object mux (white ball, red ball, hole number, holes, borders, board).
- Tracks the target hole and the score, and sequences the display through aim / roll / score / foul / game-over phases.
- Timing is frame-based: timers advance only on the per-frame start pulse.

Parameters:
- NUM_HOLES, 6, number of pockets; target index range 0..NUM_HOLES-1.
- BLINK_FRAMES, 16, frames per blink half-period.
- RESULT_FRAMES, 60, frames spent in SCORED or FOUL before returning to AIM.
- MAX_SCORE, 9, score value that ends the game.
- MIN_ROLL_FRAMES, 2, frames in ROLL before "balls stopped" is honoured.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at vertical frame start
- shotReq  in  1  one-cycle debounced key pulse
- ballsMoving  in  1  level; 1 while either ball has nonzero speed
- redPocketed  in  1  one-cycle pulse; red ball entered a pocket
- pocketHole  in  HOLE_W  pocket index, valid only with redPocketed
- whitePocketed  in  1  one-cycle pulse; white ball entered a pocket
- whiteBallEn, redBallEn, holeNumberEn, holesEn, bordersEn, boardEn  out  1 each  layer enables; the top level ANDs each with the matching drawing request
- targetHole  out  HOLE_W  current target pocket, to the hole-number drawer
- score  out  4  current score
- stateOut  out  3  encoded FSM state, for debug/LEDs

Behaviour:
- HOLE_W = $clog2(NUM_HOLES).
- All outputs are registered.
- Reset (async) values:
  - state IDLE, score 0, targetHole 0, blink 1, frameCnt 0.
  - All six enables 0 and stateOut 0 while reset is high.
- Enables reflect the current state one cycle after any state change.
- Enables per state (1 = on):
  - IDLE: board, borders, holes; holeNumber blinks.
  - AIM: all six on, holeNumber steady.
  - ROLL: all six on.
  - SCORED: board, borders, holes, white on; red off; holeNumber blinks.
  - FOUL: board, borders, holes, red, holeNumber on; white blinks.
  - GAMEOVER: board, borders on; all others off.
- Blink: a blink bit is set to 1 on every state entry and toggles every BLINK_FRAMES startOfFrame pulses. A blinking layer is enabled only while blink=1.
- frameCnt: cleared on every state entry and incremented on startOfFrame. It saturates at RESULT_FRAMES.
- Transitions:
  - IDLE: shotReq -> AIM.
  - AIM: shotReq -> ROLL.
  - ROLL, evaluated in priority order:
    1. whitePocketed -> FOUL.
    2. redPocketed with pocketHole != targetHole -> FOUL.
    3. redPocketed with pocketHole == targetHole -> SCORED.
    4. startOfFrame with ballsMoving=0 and frameCnt >= MIN_ROLL_FRAMES -> AIM (miss; score and target unchanged).
  - SCORED: when frameCnt reaches RESULT_FRAMES:
    - score+1; targetHole = (targetHole+1) wraps NUM_HOLES-1 -> 0.
    - If the new score == MAX_SCORE -> GAMEOVER, else -> AIM.
  - FOUL: when frameCnt reaches RESULT_FRAMES -> score-1, saturating at 0; -> AIM.
  - GAMEOVER: shotReq -> IDLE; score and targetHole cleared to 0.
- Simultaneous events:
  - whitePocketed and redPocketed in the same cycle (either hole) -> FOUL.
  - A pocket event coincident with startOfFrame: the event wins; the miss check is ignored.
- shotReq in ROLL, SCORED or FOUL is ignored; it is not queued.
- redPocketed and whitePocketed outside ROLL are ignored.
- Reset asserted mid-operation returns everything to reset values immediately; there is no recovery of score or target.

Decomposition:
- billiard_pkg holds:
  - typedef enum logic [2:0] seq_state_t {IDLE=0, AIM=1, ROLL=2, SCORED=3, FOUL=4, GAMEOVER=5}.
  - Constants for the default NUM_HOLES, MAX_SCORE and RESULT_FRAMES, shared with the hole-number and score drawers.
- One sub-module: frame_timer.
  - Inputs: clk, reset, clear, startOfFrame.
  - Outputs: frameCnt (saturating) and blink (toggle every BLINK_FRAMES).
  - Instanced once; cleared on state entry.

Test Plan:
- Reset high mid-ROLL with score=3, target=2 -> all enables 0 at once; after release: stateOut=0, score=0, targetHole=0; board/borders/holes =1 one cycle later.
- IDLE, shotReq, shotReq; redPocketed with pocketHole=0 (target 0) -> SCORED; red enable 0; after 60 startOfFrame pulses: score=1, targetHole=1, state AIM.
- ROLL with target=5: redPocketed pocketHole=5 -> after 60 frames targetHole wraps to 0. Same cycle with redPocketed target hole and whitePocketed -> FOUL, score unchanged at 0 after 60 frames (saturates).
- ROLL, ballsMoving=0: first startOfFrame (frameCnt 0) stays in ROLL; at frameCnt=2 -> AIM with score/target unchanged. shotReq pulses during ROLL are ignored.
- Score at 8, score a target -> GAMEOVER; only board/borders enabled; shotReq -> IDLE with score 0.
- IDLE for 64 frames: holeNumberEn toggles every 16 startOfFrame pulses, starting at 1.
